// File: rtl/game_feedback_decoder.sv
// Feedback-byte decoder for the game-state link: tracks game running state,
// completed-cuisine count, robot status and link silence from UART rx bytes.
module game_feedback_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned CNT_MAX        = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       game_running,
  output logic [2:0] complete_num,
  output logic [2:0] last_cuisine_id,
  output logic [5:0] robot_status,
  output logic       status_valid,
  output logic       frame_err,
  output logic [3:0] err_count,
  output logic       link_lost
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {
    S_STOPPED = 1'b0,
    S_RUNNING = 1'b1
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [CW-1:0]   r_tmo_cnt;
  logic [2:0]      r_complete_num;
  logic [2:0]      r_last_cuisine_id;
  logic [5:0]      r_robot_status;
  logic            r_status_valid;
  logic            r_frame_err;
  logic [3:0]      r_err_count;
  logic            r_link_lost;

  logic [1:0]      w_ch;
  logic            w_start;
  logic            w_stop;
  logic            w_cuisine;
  logic            w_robot;
  logic            w_invalid;
  logic            w_timeout;
  logic            w_running;

  assign w_ch      = rx_data[1:0];
  assign w_running = (r_state == S_RUNNING);
  assign w_start   = rx_valid && (w_ch == 2'b01) && (rx_data[3:2] == 2'b10);
  assign w_stop    = rx_valid && (w_ch == 2'b01) && (rx_data[3:2] == 2'b01);
  assign w_cuisine = rx_valid && (w_ch == 2'b10);
  assign w_robot   = rx_valid && (w_ch == 2'b11);
  // Game-state echo with action field 00 or 11 is treated like channel 00.
  assign w_invalid = rx_valid && ((w_ch == 2'b00) ||
                                  ((w_ch == 2'b01) && (rx_data[3] == rx_data[2])));
  // Any received byte in this cycle suppresses the timeout.
  assign w_timeout = w_running && !rx_valid && (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: state register uses non-blocking assignment; the next-state logic
  // below is combinational and uses blocking assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_STOPPED;
    else        r_state <= w_state_next;
  end

  // NOTE: default assignment first so every path drives w_state_next (no latch).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_STOPPED: if (w_start)              w_state_next = S_RUNNING;
      S_RUNNING: if (w_stop || w_timeout)  w_state_next = S_STOPPED;
      default:                             w_state_next = S_STOPPED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt         <= '0;
      r_complete_num    <= '0;
      r_last_cuisine_id <= '0;
      r_robot_status    <= '0;
      r_status_valid    <= 1'b0;
      r_frame_err       <= 1'b0;
      r_err_count       <= '0;
      r_link_lost       <= 1'b0;
    end else begin
      r_status_valid <= w_robot;
      r_frame_err    <= w_invalid;

      if (rx_valid || !w_running || w_timeout) r_tmo_cnt <= '0;
      else                                     r_tmo_cnt <= r_tmo_cnt + CW'(1);

      if (rx_valid)       r_link_lost <= 1'b0;
      else if (w_timeout) r_link_lost <= 1'b1;

      if (w_start && !w_running) begin
        r_complete_num <= '0;
      end else if (w_cuisine && w_running) begin
        r_last_cuisine_id <= rx_data[4:2];
        if (r_complete_num < 3'(CNT_MAX)) r_complete_num <= r_complete_num + 3'd1;
      end

      if (w_robot) r_robot_status <= rx_data[7:2];

      if (w_invalid && (r_err_count != 4'hF)) r_err_count <= r_err_count + 4'd1;
    end
  end

  assign game_running    = w_running;
  assign complete_num    = r_complete_num;
  assign last_cuisine_id = r_last_cuisine_id;
  assign robot_status    = r_robot_status;
  assign status_valid    = r_status_valid;
  assign frame_err       = r_frame_err;
  assign err_count       = r_err_count;
  assign link_lost       = r_link_lost;

endmodule
